// File: rtl/hvint_multi_if.sv
// CPU register bus for hvint_multi: strobe, read/write qualifiers, address,
// write data and combinational read data.
interface hvint_multi_if;
    logic       cpu_en;
    logic       we;
    logic       re;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output cpu_en, we, re, addr, wdata, input rdata);
    modport slave  (input cpu_en, we, re, addr, wdata, output rdata);
endinterface

// File: rtl/hvint_multi.sv
// H/V blanking detector, vblank NMI generator and NUM_CH independent
// H/V compare interrupt channels, with a small CPU-visible register file.
module hvint_multi #(
    parameter int CTR_W    = 9,
    parameter int NUM_CH   = 4,
    parameter int HDLY     = 3,
    parameter int HWIN     = 2,
    parameter int VB_NORM  = 225,
    parameter int VB_OS    = 240,
    parameter int HB_START = 274
) (
    input  logic              clk,
    input  logic              reset,
    hvint_multi_if.slave      bus,
    input  logic [CTR_W-1:0]  h_ctr,
    input  logic [CTR_W-1:0]  v_ctr,
    input  logic              overscan,
    output logic              nmi,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_src
);

    // Compares run one bit wider than the counters so HTIME+HDLY+HWIN never wraps.
    localparam int XW = CTR_W + 1;
    typedef logic [XW-1:0] ext_t;

    logic [CTR_W-1:0]  htime [NUM_CH];
    logic [CTR_W-1:0]  vtime [NUM_CH];
    logic [1:0]        mode  [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic              nmi_en;
    logic              nmi_flg;
    logic              vblank_prev;

    logic              wr_en;
    logic              rd_en;
    logic [4:0]        ch_off;
    logic [2:0]        ch_idx;
    logic [1:0]        reg_k;
    logic              ch_hit;

    ext_t              hx;
    ext_t              vx;
    logic              vblank;
    logic              hblank;
    logic              h0;
    logic [NUM_CH-1:0] heq;
    logic [NUM_CH-1:0] veq;
    logic [NUM_CH-1:0] hit;

    assign wr_en  = bus.cpu_en & bus.we;
    assign rd_en  = bus.cpu_en & bus.re;
    assign ch_off = bus.addr - 5'd8;
    assign ch_idx = ch_off[4:2];
    assign reg_k  = ch_off[1:0];
    assign ch_hit = (bus.addr >= 5'd8) && (ch_idx < 3'(NUM_CH));

    assign hx     = ext_t'(h_ctr);
    assign vx     = ext_t'(v_ctr);
    assign vblank = vx >= (overscan ? ext_t'(VB_OS) : ext_t'(VB_NORM));
    assign hblank = (hx >= ext_t'(HB_START)) | (h_ctr == '0);
    // h0 window is h_ctr in [HDLY-1, HDLY-1+HWIN); shifted by +1 to avoid a negative bound.
    assign h0     = ((hx + ext_t'(1)) >= ext_t'(HDLY)) && ((hx + ext_t'(1)) < ext_t'(HDLY + HWIN));

    assign nmi     = nmi_en & nmi_flg;
    assign irq     = |pend;
    assign irq_src = pend;

    // Per-channel match detection and mode-qualified set condition.
    always_comb begin
        heq = '0;
        veq = '0;
        hit = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            heq[c] = (hx >= (ext_t'(htime[c]) + ext_t'(HDLY))) &&
                     (hx <  (ext_t'(htime[c]) + ext_t'(HDLY) + ext_t'(HWIN)));
            veq[c] = (v_ctr == vtime[c]);
            case (mode[c])
                2'd1:    hit[c] = heq[c];
                2'd2:    hit[c] = veq[c] & h0;
                2'd3:    hit[c] = veq[c] & heq[c];
                default: hit[c] = 1'b0;
            endcase
        end
    end

    // Combinational read mux; unmapped and absent channels read zero.
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            5'h00: bus.rdata = {nmi_en, 7'h00};
            5'h01: bus.rdata = {nmi_flg, 3'h7, 4'h2};
            5'h02: bus.rdata[NUM_CH-1:0] = pend;
            5'h03: bus.rdata = {vblank, hblank, 6'h00};
            default: begin
                if (ch_hit) begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        if (ch_idx == 3'(c)) begin
                            case (reg_k)
                                2'd0: bus.rdata = htime[c][7:0];
                                2'd1: begin
                                    bus.rdata[5:4]       = mode[c];
                                    bus.rdata[CTR_W-9:0] = htime[c][CTR_W-1:8];
                                end
                                2'd2: bus.rdata = vtime[c][7:0];
                                default: bus.rdata[CTR_W-9:0] = vtime[c][CTR_W-1:8];
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    // NMI enable, vblank edge tracking and the vblank NMI flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_en      <= 1'b0;
            nmi_flg     <= 1'b0;
            vblank_prev <= 1'b1;
        end else begin
            vblank_prev <= vblank;
            if (wr_en && bus.addr == 5'h00)
                nmi_en <= bus.wdata[7];
            if (!vblank)
                nmi_flg <= 1'b0;
            else if (!vblank_prev)
                nmi_flg <= 1'b1;
            else if (rd_en && bus.addr == 5'h01)
                nmi_flg <= 1'b0;
        end
    end

    // Channel compare registers and mode fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                htime[c] <= '0;
                vtime[c] <= '0;
                mode[c]  <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (wr_en && ch_hit && ch_idx == 3'(c)) begin
                    case (reg_k)
                        2'd0: htime[c][7:0] <= bus.wdata;
                        2'd1: begin
                            htime[c][CTR_W-1:8] <= bus.wdata[CTR_W-9:0];
                            mode[c]             <= bus.wdata[5:4];
                        end
                        2'd2: vtime[c][7:0] <= bus.wdata;
                        default: vtime[c][CTR_W-1:8] <= bus.wdata[CTR_W-9:0];
                    endcase
                end
            end
        end
    end

    // Pending bits: a match sets, a disabled channel clears, then W1C clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (hit[c])
                    pend[c] <= 1'b1;
                else if (mode[c] == 2'd0)
                    pend[c] <= 1'b0;
                else if (wr_en && bus.addr == 5'h02 && bus.wdata[c])
                    pend[c] <= 1'b0;
            end
        end
    end

endmodule

// File: doc/hvint_multi.md
HVINT_MULTI -- requirements
Module: hvint_multi

Interface
REQ-001 SHALL have parameter CTR_W, default 9: width of h_ctr, v_ctr and all timer compare values.
REQ-002 SHALL have parameter NUM_CH, default 4, legal range 1..4: number of independent H/V compare channels.
REQ-003 SHALL have parameter HDLY, default 3: fixed compare offset in dots.
REQ-004 SHALL have parameter HWIN, default 2: match window length in dots.
REQ-005 SHALL have parameters VB_NORM=225, VB_OS=240 and HB_START=274: blanking thresholds.
REQ-006 SHALL have ports: clk in 1, the single clock; reset in 1, asynchronous active-high.
REQ-007 SHALL have ports: cpu_en in 1, CPU access strobe; we in 1, write; re in 1, read; addr in 5, register select; wdata in 8; rdata out 8.
REQ-008 SHALL have ports: h_ctr in CTR_W; v_ctr in CTR_W; overscan in 1.
REQ-009 SHALL have ports: nmi out 1; irq out 1; irq_src out NUM_CH, the per-channel pending vector.

Function
REQ-010 SHALL use this register map:
- 0x00 CTRL RW: bit7 nmi_en.
- 0x01 RDNMI R: {nmi_flg,3'h7,4'h2}; read-to-clear.
- 0x02 PEND R/W1C: bits[NUM_CH-1:0] pending, other bits read 0.
- 0x03 HVB R: {vblank,hblank,6'h0}.
- 0x08+4c+k for channel c: k=0 HTIME[7:0]; k=1 {mode[1:0] at bits5:4, HTIME[CTR_W-1:8] at low bits}; k=2 VTIME[7:0]; k=3 VTIME[CTR_W-1:8].
REQ-011 SHALL drive rdata combinationally from addr, regardless of re/cpu_en; unmapped addresses and channels c>=NUM_CH SHALL read 8'h00 and ignore writes.
REQ-012 SHALL perform register writes on posedge clk only when cpu_en&we; read side effects SHALL occur only when cpu_en&re.
REQ-013 SHALL compute vblank = v_ctr >= (overscan ? VB_OS : VB_NORM), and hblank = (h_ctr >= HB_START) | (h_ctr == 0).
REQ-014 SHALL register vblank_prev each cycle; nmi_flg priority: ~vblank clears > vblank&~vblank_prev sets > RDNMI read clears.
REQ-015 SHALL drive nmi = nmi_en & nmi_flg, combinationally from flops.
REQ-016 SHALL evaluate all compare arithmetic at CTR_W+1 bits with no wrap: heq_c = h_ctr >= HTIME_c+HDLY and h_ctr < HTIME_c+HDLY+HWIN; h0 = h_ctr >= HDLY-1 and h_ctr < HDLY-1+HWIN; veq_c = v_ctr == VTIME_c.
REQ-017 SHALL set channel c per mode: 0 none; 1 heq_c; 2 veq_c&h0; 3 veq_c&heq_c.
REQ-018 SHALL apply pend_c priority: set condition > mode_c==0 clears > W1C write to PEND with wdata[c]=1 clears; set SHALL win over a same-cycle clear.
REQ-019 SHALL drive irq_src = pend vector, and irq = |pend; both have 1-cycle latency from the set condition.
REQ-020 SHALL let a channel whose HTIME+HDLY >= 2^CTR_W (or past the line length) never match in modes 1/3; there SHALL be no wrap into the next line.
REQ-021 SHALL not clear pending bits on a channel's HTIME/VTIME write.

Reset
REQ-022 SHALL, on reset asserted, asynchronously clear nmi_en, nmi_flg, all pend, HTIME/VTIME and mode to 0, so nmi=0, irq=0, irq_src=0.
REQ-023 SHALL set vblank_prev to 1 on reset, so reset release mid-vblank raises no NMI until the next vblank rising edge.
REQ-024 SHALL, on reset mid-match window, keep pend cleared, because mode=0 after reset.

Verification
REQ-025 SHALL cover NMI: nmi_en=1, overscan=0, v_ctr 224->225 -> nmi_flg=1 next cycle; RDNMI read -> 8'hF2 then 8'h72; v_ctr 261->0 clears.
REQ-026 SHALL cover H-IRQ: ch0 mode1, HTIME=100 -> irq rises cycle after h_ctr=103; PEND W1C 0x01 at h_ctr=104 -> stays set; W1C at 110 -> irq=0.
REQ-027 SHALL cover HV multi-channel: ch1 mode3 H=20,V=50 and ch2 mode2 V=50 -> at v_ctr=50, irq_src=4'b0100 after h_ctr=2, 4'b0110 after h_ctr=23.
REQ-028 SHALL cover boundary: ch3 mode1 HTIME=510 -> no irq over a full frame; mode write 0 with pending set -> pend cleared next cycle.
REQ-029 SHALL cover reset: assert reset at v_ctr=230 with pend=4'hF -> all outputs 0 immediately; release -> no NMI until next 224->225 transition.
